// File: rtl/queue_rr_arbiter.sv
// Round-robin arbiter merging N DTI queue inputs into one output, one whole
// transaction (first beat through eot beat) at a time; each beat is tagged with its source index.
module queue_rr_arbiter #(
   parameter int N = 2,
   parameter int W_DIN = 16,
   localparam int W_SEL = $clog2(N)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N*W_DIN-1:0]     din_data,
   input  logic [N-1:0]           din_valid,
   output logic [N-1:0]           din_ready,
   output logic [W_SEL+W_DIN-1:0] dout_data,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic                   busy,
   output logic [W_SEL-1:0]       cur_sel
);

   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [W_SEL-1:0] sel_q, sel_d;
   logic [W_SEL-1:0] rr_ptr_q, rr_ptr_d;
   logic [W_SEL-1:0] win;
   logic             found;
   logic [W_DIN-1:0] din_arr [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign din_arr[gi] = din_data[gi*W_DIN +: W_DIN];
   end

   function automatic logic [W_SEL-1:0] wrap_inc(input logic [W_SEL-1:0] a, input int k);
      int s;
      s = int'(a) + k;
      if (s >= N) s = s - N;
      return W_SEL'(s);
   endfunction

   // Winner depends only on valids and rr_ptr, so it stays put while the source holds its beat.
   always_comb begin
      logic [W_SEL-1:0] idx;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = wrap_inc(rr_ptr_q, k);
         if (!found && din_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      rr_ptr_d   = rr_ptr_q;
      dout_data  = '0;
      dout_valid = 1'b0;
      din_ready  = '0;
      if (!rst) begin
         case (state_q)
            S_IDLE: begin
               if (found) begin
                  dout_data      = {win, din_arr[win]};
                  dout_valid     = 1'b1;
                  din_ready[win] = dout_ready;
                  if (dout_ready) begin
                     // A single-beat transaction never takes the lock.
                     if (din_arr[win][W_DIN-1]) begin
                        rr_ptr_d = wrap_inc(win, 1);
                     end else begin
                        state_d = S_LOCKED;
                        sel_d   = win;
                     end
                  end
               end
            end
            S_LOCKED: begin
               dout_data        = {sel_q, din_arr[sel_q]};
               dout_valid       = din_valid[sel_q];
               din_ready[sel_q] = dout_ready;
               if (din_valid[sel_q] && dout_ready && din_arr[sel_q][W_DIN-1]) begin
                  state_d  = S_IDLE;
                  rr_ptr_d = wrap_inc(sel_q, 1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sel_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign busy    = (state_q == S_LOCKED);
   assign cur_sel = sel_q;

endmodule

// File: tb/tb_queue_rr_arbiter.sv
// Bench for queue_rr_arbiter (N=4): per-input source queues, a transaction-level
// arbitration model, directed scenarios and a long random run.
module tb_queue_rr_arbiter;

   localparam int N = 4;
   localparam int W = 16;

   logic          clk;
   logic          rst;
   logic [N*W-1:0] din_data;
   logic [N-1:0]  din_valid;
   logic [N-1:0]  din_ready;
   logic [17:0]   dout_data;
   logic          dout_valid;
   logic          dout_ready;
   logic          busy;
   logic [1:0]    cur_sel;

   queue_rr_arbiter #(.N(N), .W_DIN(W)) dut (
      .clk(clk), .rst(rst),
      .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
      .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .busy(busy), .cur_sel(cur_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] src_q [N][$];
   bit    pres [N];
   int    pause [N];
   int    waitc [N];
   int    vprob = 100;
   int    rprob = 100;
   bit    m_lock;
   int    m_owner, m_ptr, m_sel;
   int    log_q [$];
   bit    busy_log [$];
   int    total = 0;
   int    bad = 0;
   int    seq = 0;
   string cur_test = "init";
   logic        obs_valid, obs_busy;
   logic [3:0]  obs_ready;
   logic [17:0] obs_data;
   logic [1:0]  obs_sel;

   task automatic push_trans(input int i, input int len);
      for (int b = 0; b < len; b++) begin
         src_q[i].push_back({(b == len - 1), 15'(seq)});
         seq++;
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (pause[i] > 0) pause[i]--;
         else if (!pres[i] && src_q[i].size() > 0 && int'($urandom_range(99)) < vprob) pres[i] = 1'b1;
         din_valid[i] = pres[i];
         din_data[i*W +: W] = pres[i] ? src_q[i][0] : W'($urandom);
      end
      dout_ready = (int'($urandom_range(99)) < rprob);
   endtask

   // One clock: drive at negedge, check combinational and registered outputs, advance the model.
   task automatic tick();
      int src;
      bit ev;
      logic [3:0] exp_rdy;
      logic [W-1:0] beat;
      int j;
      drive_inputs();
      #1;
      obs_valid = dout_valid; obs_ready = din_ready; obs_data = dout_data;
      obs_busy = busy; obs_sel = cur_sel;
      src = -1;
      ev = 1'b0;
      if (!rst) begin
         if (m_lock) begin
            src = m_owner;
            ev = pres[src];
         end else begin
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (src < 0 && pres[j]) src = j;
            end
            ev = (src >= 0);
         end
      end
      exp_rdy = '0;
      if (src >= 0) exp_rdy[src] = dout_ready;
      total++;
      if (dout_valid !== ev) begin
         bad++; $display("FAIL %s dout_valid: got %b want %b", cur_test, dout_valid, ev);
      end
      if (ev) begin
         total++;
         if (dout_data !== {2'(src), src_q[src][0]}) begin
            bad++; $display("FAIL %s dout_data: got %h want %h", cur_test, dout_data, {2'(src), src_q[src][0]});
         end
      end
      total++;
      if (din_ready !== exp_rdy) begin
         bad++; $display("FAIL %s din_ready: got %b want %b", cur_test, din_ready, exp_rdy);
      end
      total++;
      if (busy !== m_lock) begin
         bad++; $display("FAIL %s busy: got %b want %b", cur_test, busy, m_lock);
      end
      total++;
      if (cur_sel !== 2'(m_sel)) begin
         bad++; $display("FAIL %s cur_sel: got %0d want %0d", cur_test, cur_sel, m_sel);
      end
      if (ev && dout_ready) begin
         beat = src_q[src].pop_front();
         pres[src] = 1'b0;
         log_q.push_back(int'(dout_data[17:16]));
         busy_log.push_back(busy);
         if (!m_lock) begin
            for (int k = 0; k < N; k++) begin
               if (k != src && pres[k]) begin
                  waitc[k]++;
                  total++;
                  if (waitc[k] > 3) begin
                     bad++; $display("FAIL %s fairness in%0d: got %0d grants waited want <=3", cur_test, k, waitc[k]);
                  end
               end
            end
            waitc[src] = 0;
         end
         if (beat[W-1]) begin
            m_lock = 1'b0;
            m_ptr = (src + 1) % N;
         end else begin
            if (!m_lock) m_sel = src;
            m_lock = 1'b1;
            m_owner = src;
         end
      end
      if (rst) begin
         m_lock = 1'b0; m_sel = 0; m_ptr = 0;
      end
      @(negedge clk);
   endtask

   task automatic run_until(input int n, input int limit);
      int c = 0;
      while (log_q.size() < n && c < limit) begin
         tick();
         c++;
      end
      total++;
      if (log_q.size() < n) begin
         bad++; $display("FAIL %s timeout: got %0d beats want %0d", cur_test, log_q.size(), n);
      end
   endtask

   task automatic drain();
      int c = 0;
      int left;
      vprob = 100; rprob = 100;
      left = 1;
      while (left != 0 && c < 400) begin
         tick();
         c++;
         left = int'(m_lock);
         for (int i = 0; i < N; i++) left += src_q[i].size();
      end
      total++;
      if (left != 0) begin
         bad++; $display("FAIL %s drain: got %0d beats left want 0", cur_test, left);
      end
   endtask

   task automatic test_reset();
      cur_test = "reset";
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tick();
      total++;
      if (obs_valid !== 1'b0 || obs_ready !== 4'b0 || obs_busy !== 1'b0 || obs_sel !== 2'd0) begin
         bad++; $display("FAIL reset outputs: got v=%b r=%b busy=%b sel=%0d want 0 0000 0 0",
                         obs_valid, obs_ready, obs_busy, obs_sel);
      end
      rst = 1'b0;
   endtask

   task automatic test_round_robin();
      cur_test = "round_robin";
      log_q.delete(); busy_log.delete();
      push_trans(0, 3); push_trans(0, 3);
      for (int i = 1; i < N; i++) push_trans(i, 3);
      run_until(15, 40);
      for (int k = 0; k < 15 && k < log_q.size(); k++) begin
         total++;
         if (log_q[k] != (k / 3) % N || busy_log[k] !== (k % 3 != 0)) begin
            bad++; $display("FAIL round_robin beat%0d: got sel=%0d busy=%b want sel=%0d busy=%b",
                            k, log_q[k], busy_log[k], (k / 3) % N, (k % 3 != 0));
         end
      end
   endtask

   task automatic test_single_beat();
      cur_test = "single_beat";
      log_q.delete(); busy_log.delete();
      for (int b = 0; b < 6; b++) push_trans(2, 1);
      run_until(6, 6);
      for (int k = 0; k < log_q.size(); k++) begin
         total++;
         if (log_q[k] != 2 || busy_log[k] !== 1'b0) begin
            bad++; $display("FAIL single_beat beat%0d: got sel=%0d busy=%b want sel=2 busy=0", k, log_q[k], busy_log[k]);
         end
      end
   endtask

   task automatic test_stall();
      cur_test = "stall";
      log_q.delete();
      push_trans(1, 3);
      run_until(1, 5);
      pause[1] = 5;
      push_trans(0, 2); push_trans(3, 2);
      repeat (5) begin
         tick();
         total++;
         if (obs_valid !== 1'b0 || obs_ready[0] !== 1'b0 || obs_ready[3] !== 1'b0) begin
            bad++; $display("FAIL stall idle: got v=%b r=%b want v=0 r0=0 r3=0", obs_valid, obs_ready);
         end
      end
      total++;
      if (log_q.size() != 1) begin
         bad++; $display("FAIL stall beats: got %0d want 1", log_q.size());
      end
      run_until(3, 10);
      for (int k = 1; k < 3 && k < log_q.size(); k++) begin
         total++;
         if (log_q[k] != 1) begin
            bad++; $display("FAIL stall resume beat%0d: got sel=%0d want 1", k, log_q[k]);
         end
      end
      drain();
   endtask

   task automatic test_back_pressure();
      logic [17:0] held;
      cur_test = "back_pressure";
      log_q.delete();
      push_trans(2, 4);
      run_until(1, 5);
      rprob = 0;
      held = {2'd2, src_q[2][0]};
      repeat (4) begin
         tick();
         total++;
         if (obs_valid !== 1'b1 || obs_data !== held || obs_ready !== 4'b0) begin
            bad++; $display("FAIL back_pressure hold: got v=%b d=%h r=%b want v=1 d=%h r=0000",
                            obs_valid, obs_data, obs_ready, held);
         end
      end
      total++;
      if (log_q.size() != 1) begin
         bad++; $display("FAIL back_pressure beats: got %0d want 1", log_q.size());
      end
      rprob = 100;
      run_until(4, 10);
      total++;
      if (log_q.size() != 4 || log_q[1] != 2 || log_q[3] != 2) begin
         bad++; $display("FAIL back_pressure tail: got %0d beats want 4 on sel 2", log_q.size());
      end
   endtask

   task automatic test_reset_locked();
      cur_test = "reset_locked";
      log_q.delete();
      push_trans(3, 3);
      run_until(1, 5);
      push_trans(0, 2);
      rst = 1'b1;
      tick();
      total++;
      if (obs_valid !== 1'b0 || obs_ready !== 4'b0) begin
         bad++; $display("FAIL reset_locked gate: got v=%b r=%b want 0 0000", obs_valid, obs_ready);
      end
      rst = 1'b0;
      log_q.delete();
      tick();
      total++;
      if (obs_busy !== 1'b0 || obs_sel !== 2'd0) begin
         bad++; $display("FAIL reset_locked regs: got busy=%b sel=%0d want 0 0", obs_busy, obs_sel);
      end
      total++;
      if (log_q.size() != 1 || log_q[0] != 0) begin
         bad++; $display("FAIL reset_locked first grant: got %0d beats sel=%0d want 1 beat sel=0",
                         log_q.size(), (log_q.size() > 0) ? log_q[0] : -1);
      end
      drain();
   endtask

   task automatic test_random();
      cur_test = "random";
      vprob = 60; rprob = 70;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++)
            if (src_q[i].size() < 2 && $urandom_range(3) == 0) push_trans(i, int'($urandom_range(1, 4)));
         tick();
      end
      drain();
   endtask

   initial begin
      rst = 1'b1;
      din_data = '0; din_valid = '0; dout_ready = 1'b0;
      m_lock = 1'b0; m_owner = 0; m_ptr = 0; m_sel = 0;
      for (int i = 0; i < N; i++) begin
         pres[i] = 1'b0; pause[i] = 0; waitc[i] = 0;
      end
      test_reset();
      test_round_robin();
      test_single_beat();
      test_stall();
      test_back_pressure();
      test_reset_locked();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
